// File: rtl/eq_fir_pkg.sv
// Shared constants, width helpers, saturation and FSM state type for the
// time-multiplexed equalizer FIR (optional EQ_COEF_DOUBLE_BUF_EN adds coefficient banking).
package eq_fir_pkg;

    localparam int DW   = 24;
    localparam int CW   = 12;
    localparam int FRAC = 11;
    localparam int PW   = DW + CW;
    localparam int SATW = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_EMIT
    } state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int sel_w(input int v);
        return (v > 1) ? clog2(v) : 1;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int n);
        return dw + cw + clog2(n);
    endfunction

    function automatic logic signed [DW-1:0] sat_shift(input logic signed [SATW-1:0] acc,
                                                       input int frac, input int dw);
        logic signed [SATW-1:0] sh;
        logic signed [SATW-1:0] hi;
        logic signed [SATW-1:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sh > hi) sh = hi;
        else if (sh < lo) sh = lo;
        return sh[DW-1:0];
    endfunction

endpackage

// File: rtl/eq_fir_mac_unit.sv
// Registered multiply, per-band accumulate with clear on the first tap,
// and saturated band result registers.
module eq_fir_mac_unit
    import eq_fir_pkg::*;
#(
    parameter int AW    = 41,
    parameter int BANDS = 3,
    parameter int BW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_p0,
    input  logic                 first_p0,
    input  logic                 last_p0,
    input  logic [BW-1:0]        band_p0,
    input  logic signed [DW-1:0] smp_p0,
    input  logic signed [CW-1:0] coef_p0,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [BW-1:0]        out_band,
    output logic signed [DW-1:0] out_data
);

    logic signed [PW-1:0] prod_p1;
    logic                 vld_p1;
    logic                 first_p1;
    logic                 last_p1;
    logic [BW-1:0]        band_p1;
    logic signed [AW-1:0] acc_p2;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_sum;

    // p0 -> p1: product register
    always_ff @(posedge clk) begin
        prod_p1  <= PW'(smp_p0) * PW'(coef_p0);
        first_p1 <= first_p0;
        last_p1  <= last_p0;
        band_p1  <= band_p0;
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    assign prod_ext = {{(AW-PW){prod_p1[PW-1]}}, prod_p1};
    assign acc_sum  = first_p1 ? prod_ext : acc_p2 + prod_ext;

    // p1 -> p2: accumulator and band result
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p2    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_band  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= vld_p1 && last_p1;
            if (vld_p1) acc_p2 <= acc_sum;
            if (vld_p1 && last_p1) begin
                out_data <= sat_shift({{(SATW-AW){acc_sum[AW-1]}}, acc_sum}, FRAC, DW);
                out_band <= band_p1;
                out_last <= (band_p1 == BW'(BANDS - 1));
            end
        end
    end

endmodule

// File: rtl/eq_fir_band_scheduler.sv
// Sequences one shared MAC over BANDS x N taps from a common circular delay line.
// EQ_COEF_DOUBLE_BUF_EN: shadow/active coefficient banks swapped at sample acceptance.
module eq_fir_band_scheduler
    import eq_fir_pkg::*;
#(
    parameter  int N     = 31,
    parameter  int BANDS = 3,
    localparam int TW    = clog2(N),
    localparam int BW    = sel_w(BANDS),
    localparam int AW    = acc_w(DW, CW, N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic signed [DW-1:0] sample_in,
    output logic                 busy,
    input  logic                 coef_we,
    input  logic [BW-1:0]        coef_band,
    input  logic [TW-1:0]        coef_idx,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    output logic [BW-1:0]        out_band,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 overrun,
    input  logic                 clear_overrun
`ifdef EQ_COEF_DOUBLE_BUF_EN
    ,
    input  logic                 coef_swap,
    output logic                 swap_pending
`endif
);

    state_t               state;
    logic [TW-1:0]        wp;
    logic [TW-1:0]        wp_nxt;
    logic [TW-1:0]        tap;
    logic [BW-1:0]        band;
    logic [TW-1:0]        rd_idx;
    logic [TW:0]          rd_sum;
    logic                 coef_ok;
    logic signed [DW-1:0] dly [N];
    logic signed [DW-1:0] smp_p0;
    logic signed [CW-1:0] coef_p0;
    logic                 vld_p0;
    logic                 first_p0;
    logic                 last_p0;

`ifdef EQ_COEF_DOUBLE_BUF_EN
    logic signed [CW-1:0] coef [2][BANDS][N];
    logic                 bank_sel;
    logic                 shadow_sel;
    assign shadow_sel = ~bank_sel;
    assign coef_p0    = coef[bank_sel][band][tap];
`else
    logic signed [CW-1:0] coef [BANDS][N];
    assign coef_p0 = coef[band][tap];
`endif

    assign wp_nxt  = (wp == TW'(N - 1)) ? '0 : wp + 1'b1;
    // Newest sample sits at wp; older taps walk backwards and wrap below zero.
    assign rd_sum  = {1'b0, wp} + (TW+1)'(N) - {1'b0, tap};
    assign rd_idx  = (wp >= tap) ? (wp - tap) : rd_sum[TW-1:0];
    assign smp_p0  = dly[rd_idx];
    assign vld_p0  = (state == S_MAC);
    assign first_p0 = (tap == '0);
    assign last_p0  = (tap == TW'(N - 1));
    assign coef_ok  = (int'(coef_band) < BANDS) && (int'(coef_idx) < N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wp      <= '0;
            tap     <= '0;
            band    <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < N; i++) dly[i] <= '0;
`ifdef EQ_COEF_DOUBLE_BUF_EN
            bank_sel     <= 1'b0;
            swap_pending <= 1'b0;
`endif
        end else begin
            // A fresh overrun outranks a simultaneous clear.
            if (sample_valid && busy) overrun <= 1'b1;
            else if (clear_overrun)   overrun <= 1'b0;
`ifdef EQ_COEF_DOUBLE_BUF_EN
            if (coef_swap) swap_pending <= 1'b1;
`endif
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        wp          <= wp_nxt;
                        dly[wp_nxt] <= sample_in;
                        tap         <= '0;
                        band        <= '0;
                        busy        <= 1'b1;
                        state       <= S_MAC;
`ifdef EQ_COEF_DOUBLE_BUF_EN
                        if (swap_pending || coef_swap) begin
                            bank_sel     <= ~bank_sel;
                            swap_pending <= 1'b0;
                        end
`endif
                    end
                end
                S_MAC: begin
                    if (tap == TW'(N - 1)) begin
                        tap <= '0;
                        if (band == BW'(BANDS - 1)) state <= S_DRAIN;
                        else                        band  <= band + 1'b1;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                S_DRAIN: state <= S_EMIT;
                S_EMIT: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef EQ_COEF_DOUBLE_BUF_EN
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < BANDS; b++)
                    for (int k = 0; k < N; k++) coef[s][b][k] <= '0;
`else
            for (int b = 0; b < BANDS; b++)
                for (int k = 0; k < N; k++) coef[b][k] <= '0;
`endif
        end else if (coef_we && coef_ok) begin
`ifdef EQ_COEF_DOUBLE_BUF_EN
            coef[shadow_sel][coef_band][coef_idx] <= coef_data;
`else
            coef[coef_band][coef_idx] <= coef_data;
`endif
        end
    end

    eq_fir_mac_unit #(
        .AW    (AW),
        .BANDS (BANDS),
        .BW    (BW)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .vld_p0    (vld_p0),
        .first_p0  (first_p0),
        .last_p0   (last_p0),
        .band_p0   (band),
        .smp_p0    (smp_p0),
        .coef_p0   (coef_p0),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_band  (out_band),
        .out_data  (out_data)
    );

endmodule
